// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the pulse_hs_tx req/ack pulse-crossing transmitter.
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } hs_state_e;

  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned GAP_CYC_DEF     = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer with synchronous active-high reset.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_hs_tx.sv
// Source-side four-phase req/ack transmitter: queues event pulses and sends one handshake each.
// Optional ack timeout (timeout_err port) is enabled by defining PULSE_HS_TX_TIMEOUT_EN.
module pulse_hs_tx
  import pulse_hs_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             done_pulse,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef PULSE_HS_TX_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int unsigned     GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  hs_state_e        state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ack_s;
  logic             launch;
  logic             ovf_set;
  logic             timeout_hit;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

`ifdef PULSE_HS_TX_TIMEOUT_EN
  localparam int unsigned      TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_q, wait_d;
  logic            tout_q, tout_d;

  // Only fires while the awaited ack edge has not arrived; a same-cycle ack wins.
  always_comb begin
    timeout_hit = (((state_q == REQ) && !ack_s) || ((state_q == DROP) && ack_s))
                  && (wait_q == TO_LAST);
    wait_d      = (state_d != state_q) ? '0 : wait_q + 1'b1;
    tout_d      = tout_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tout_q <= tout_d;
    end
  end

  assign timeout_err = tout_q;
`else
  // TIMEOUT_CYC is kept in the parameter list so overrides stay valid in every build.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      gap_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if ((pend_q != '0) && !ack_s) state_d = REQ;
      REQ: begin
        if (ack_s)            state_d = DROP;
        else if (timeout_hit) state_d = (GAP_CYC == 0) ? IDLE : GAP;
      end
      DROP: if (!ack_s || timeout_hit) state_d = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:  if (gap_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch  = (state_q == IDLE) && (state_d == REQ);
    req_d   = (state_d == REQ);
    done_d  = (state_q == DROP) && !ack_s;
    gap_d   = (state_q == GAP) ? gap_q + 1'b1 : '0;
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (pulse_in && !launch) begin
      if (pend_q == '1) ovf_set = 1'b1;
      else              pend_d  = pend_q + 1'b1;
    end else if (!pulse_in && launch) begin
      pend_d = pend_q - 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  assign req_out    = req_q;
  assign pending    = pend_q;
  assign busy       = (state_q != IDLE) || (pend_q != '0);
  assign done_pulse = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pulse_hs_tx.sv
// Bench for pulse_hs_tx: receiver models ack after a fixed delay; req widths are scoreboarded.
module tb_pulse_hs_tx;

  localparam int unsigned ACK_DLY     = 3;
  localparam int unsigned SAT_ACK_DLY = 8;
  localparam int unsigned SYNC        = 2;
  localparam int unsigned TO_CYC      = 8;
  localparam int unsigned W_NORM      = ACK_DLY + SYNC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in, ack_in, req_out, busy, done_pulse, overflow, clr_ovf;
  logic [3:0] pending;
  logic       s_pulse, s_ack, s_req, s_busy, s_done, s_ovf, s_clr;
  logic [1:0] s_pend;
`ifdef PULSE_HS_TX_TIMEOUT_EN
  logic       timeout_err, s_tout;
`endif

  always #5 clk = ~clk;

  pulse_hs_tx #(
    .CNT_W(4), .SYNC_STAGES(SYNC), .GAP_CYC(2), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .ack_in(ack_in), .req_out(req_out),
    .pending(pending), .busy(busy), .done_pulse(done_pulse), .overflow(overflow),
    .clr_ovf(clr_ovf)
`ifdef PULSE_HS_TX_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  pulse_hs_tx #(
    .CNT_W(2), .SYNC_STAGES(SYNC), .GAP_CYC(2), .TIMEOUT_CYC(64)
  ) dut_sat (
    .clk(clk), .rst(rst), .pulse_in(s_pulse), .ack_in(s_ack), .req_out(s_req),
    .pending(s_pend), .busy(s_busy), .done_pulse(s_done), .overflow(s_ovf),
    .clr_ovf(s_clr)
`ifdef PULSE_HS_TX_TIMEOUT_EN
    , .timeout_err(s_tout)
`endif
  );

  // Receiver models: 0 = echo req after a delay, 1 = ack stuck high, 2 = silent.
  int unsigned ack_mode = 0;
  logic [2:0]  pipe_q;
  logic [7:0]  s_pipe_q;

  always @(posedge clk) begin
    if (rst) begin
      pipe_q   <= '0;
      s_pipe_q <= '0;
    end else begin
      pipe_q   <= {pipe_q[1:0], req_out && (ack_mode != 2)};
      s_pipe_q <= {s_pipe_q[6:0], s_req};
    end
  end

  always_comb ack_in = (ack_mode == 1) ? 1'b1 : pipe_q[ACK_DLY-1];
  assign s_ack = s_pipe_q[SAT_ACK_DLY-1];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int unsigned exp_w_q[$];
  int unsigned req_w = 0, done_cnt = 0, pend_max = 0;
  int unsigned s_req_cnt = 0, s_done_cnt = 0, s_pend_max = 0;
  logic        req_prev = 1'b0, done_prev = 1'b0, s_req_prev = 1'b0;

  always @(negedge clk) begin
    if (req_out) begin
      req_w++;
    end else if (req_prev) begin
      if (!rst) begin
        if (exp_w_q.size() == 0) check("sb_depth", 0, 1);
        else                     check("req_width", req_w, exp_w_q.pop_front());
      end
      req_w = 0;
    end
    if (done_pulse) begin
      done_cnt++;
      if (done_prev) check("done_1cyc", 2, 1);
    end
    if (pending > pend_max) pend_max = pending;
    req_prev  = req_out;
    done_prev = done_pulse;
    if (s_req && !s_req_prev) s_req_cnt++;
    if (s_done) s_done_cnt++;
    if (s_pend > s_pend_max) s_pend_max = s_pend;
    s_req_prev = s_req;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic level, input int unsigned budget);
    int unsigned n = 0;
    while (req_out != level && n < budget) begin step(); n++; end
    check(tag, req_out, level);
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!done_pulse && n < budget) begin step(); n++; end
    check(tag, done_pulse, 1);
  endtask

  task automatic wait_main_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (busy && n < budget) begin step(); n++; end
    check(tag, busy, 0);
  endtask

  task automatic wait_sat_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (s_busy && n < budget) begin step(); n++; end
    check(tag, s_busy, 0);
  endtask

  task automatic pulse_main(input int unsigned n, input int unsigned width);
    for (int unsigned i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      exp_w_q.push_back(width);
      step();
    end
    pulse_in = 1'b0;
  endtask

  int unsigned dc0;

  initial begin
    rst = 1'b1; pulse_in = 1'b0; clr_ovf = 1'b0; s_pulse = 1'b0; s_clr = 1'b0;
    repeat (3) step();
    check("rst_req", req_out, 0);
    check("rst_pend", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_ovf", overflow, 0);
    check("rst_s_pend", s_pend, 0);
    rst = 1'b0;
    step();

    // single event
    pulse_main(1, W_NORM);
    check("lat_pend1", pending, 1);
    check("lat_req0", req_out, 0);
    step();
    check("lat_req1", req_out, 1);
    wait_done("single_done", 40);
    check("gap_busy0", busy, 1);
    step();
    check("gap_busy1", busy, 1);
    step();
    check("gap_idle", busy, 0);
    check("single_pend", pending, 0);
    check("single_dones", done_cnt, 1);

    // burst of 5
    pend_max = 0;
    dc0 = done_cnt;
    pulse_main(5, W_NORM);
    wait_main_idle("burst_idle", 400);
    check("burst_peak", pend_max, 4);
    check("burst_dones", done_cnt - dc0, 5);
    check("burst_ovf", overflow, 0);
    check("burst_sb_empty", exp_w_q.size(), 0);

    // saturation on the 2-bit instance
    s_req_cnt = 0; s_done_cnt = 0; s_pend_max = 0;
    for (int unsigned i = 0; i < 6; i++) begin s_pulse = 1'b1; step(); end
    s_pulse = 1'b0;
    check("sat_peak", s_pend_max, 3);
    check("sat_pend", s_pend, 3);
    check("sat_ovf", s_ovf, 1);
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    check("sat_clr", s_ovf, 0);
    wait_sat_idle("sat_idle", 400);
    check("sat_hs", s_req_cnt, 4);
    check("sat_dones", s_done_cnt, 4);
    check("sat_ovf_after", s_ovf, 0);

    // reset while in REQ
    dc0 = done_cnt;
    pulse_main(3, W_NORM);
    check("pre_rst_req", req_out, 1);
    check("pre_rst_pend", pending, 2);
    exp_w_q.delete();
    rst = 1'b1;
    step();
    check("rstreq_req", req_out, 0);
    check("rstreq_pend", pending, 0);
    check("rstreq_busy", busy, 0);
    rst = 1'b0;
    repeat (20) step();
    check("rstreq_nodone", done_cnt - dc0, 0);
    check("rstreq_quiet", req_out, 0);

    // stale ack
    ack_mode = 1;
    repeat (4) step();
    dc0 = done_cnt;
    pulse_main(1, W_NORM);
    repeat (5) step();
    check("stale_req", req_out, 0);
    check("stale_pend", pending, 1);
    ack_mode = 0;
    wait_req("stale_launch", 1'b1, 10);
    wait_main_idle("stale_idle", 60);
    check("stale_dones", done_cnt - dc0, 1);

`ifdef PULSE_HS_TX_TIMEOUT_EN
    check("to_err0", timeout_err, 0);
    ack_mode = 2;
    dc0 = done_cnt;
    pulse_in = 1'b1; exp_w_q.push_back(TO_CYC); step();
    pulse_in = 1'b1; exp_w_q.push_back(W_NORM); step();
    pulse_in = 1'b0;
    wait_req("to_rise", 1'b1, 5);
    wait_req("to_fall", 1'b0, TO_CYC + 4);
    check("to_err", timeout_err, 1);
    check("to_nodone", done_cnt - dc0, 0);
    ack_mode = 0;
    wait_main_idle("to_idle", 80);
    check("to_dones", done_cnt - dc0, 1);
    check("to_sticky", timeout_err, 1);
`endif

    check("sb_empty", exp_w_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_hs_tx.md
Name: pulse_hs_tx

Overview:
- Transmit side of a four-phase req/ack pulse-crossing link. It runs in the source clock domain and queues single-cycle event pulses in a pending counter.
- Each queued event is delivered to the far (destination) domain as one full req/ack handshake. Bursty pulses are therefore never lost, unlike a raw pulse synchronizer.
- The far-domain receiver returns ack. This block synchronizes ack internally.

Parameters:
- CNT_W, 4: width of the pending-event counter; saturates at 2^CNT_W-1.
- SYNC_STAGES, 2: flop stages on ack_in; legal range 2..4.
- GAP_CYC, 2: idle cycles forced after each completed handshake; 0 means none.
- TIMEOUT_CYC, 64: ack wait limit in clk cycles; used only with the optional feature.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- pulse_in, input, 1: one-cycle event request. Consecutive high cycles count as separate events.
- ack_in, input, 1: asynchronous ack from the far domain.
- req_out, output, 1: registered level request to the far domain.
- pending, output, CNT_W: number of queued events not yet launched.
- busy, output, 1: state != IDLE or pending != 0.
- done_pulse, output, 1: one-cycle strobe when a handshake fully completes.
- overflow, output, 1: sticky flag, set when an event is dropped at saturation.
- clr_ovf, input, 1: clears overflow. Set has priority over clear in the same cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; pending=0; req_out=0; done_pulse=0; overflow=0.
  - ack sync chain=0; gap counter=0.
- Ack synchronization: ack_s is ack_in after SYNC_STAGES flops. The FSM uses only ack_s.
- Pending counter:
  - +1 on pulse_in; -1 on launch (IDLE->REQ).
  - pulse_in and launch in the same cycle: pending is unchanged.
  - pulse_in while pending is at max and no launch that cycle: pending holds, overflow sets next cycle.
- FSM states: IDLE, REQ, DROP, GAP.
  - IDLE: if pending != 0 and ack_s == 0, go to REQ. req_out=1 from the next cycle. Latency from the first pulse_in in IDLE to req_out high is 2 cycles.
  - IDLE with ack_s still high (stale ack): stay in IDLE.
  - REQ: hold req_out=1 until ack_s == 1, then go to DROP. req_out=0 from the next cycle.
  - DROP: wait for ack_s == 0. On that transition, done_pulse=1 for exactly one cycle.
  - DROP exit: go to GAP if GAP_CYC > 0, otherwise directly to IDLE.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Throughput: at most one event per handshake. Back-to-back events are separated by the ack round trip plus GAP_CYC.
- Reset mid-handshake: req_out drops immediately at the reset edge and the queued events are discarded. Both domains are reset together at system level; the receiver is not required to survive a one-sided reset.
- pulse_in during REQ, DROP or GAP is queued normally.

Optional Feature:
- Macro: PULSE_HS_TX_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky, cleared by rst only).
  - A wait counter runs in REQ and DROP and restarts on each state entry.
  - Reaching TIMEOUT_CYC: set timeout_err, force req_out=0, go to GAP. No done_pulse is issued and the event counts as lost.
- Undefined: no timeout_err port and no counter; the FSM waits indefinitely for ack.

Decomposition:
- Package pulse_hs_pkg holds:
  - state encoding typedef (IDLE=2'd0, REQ=2'd1, DROP=2'd2, GAP=2'd3);
  - default parameter constants.
- One sub-module, sync_ff: a SYNC_STAGES-deep synchronizer with synchronous active-high reset, used for ack_in.

Test Plan:
- Single event: one pulse_in after reset; a bench receiver model acks 3 cycles after req.
  - Required: req_out rises 2 cycles after pulse_in and falls 1 cycle after ack_s rises.
  - Required: done_pulse fires once; pending returns to 0; busy goes low after GAP.
- Burst: pulse_in high for 5 consecutive cycles.
  - Required: pending peaks at 4 (one event launched during the burst).
  - Required: exactly 5 handshakes and 5 done_pulse strobes; no overflow.
- Saturation (CNT_W=2, slow ack): 6 pulses.
  - Required: pending saturates at 3; overflow=1.
  - Required: clr_ovf with no simultaneous drop returns overflow to 0; 4 handshakes total.
- Reset in REQ: assert rst while req_out=1.
  - Required: next cycle req_out=0, pending=0, state=IDLE, done_pulse never asserted.
- Stale ack: ack_in held high at the moment pending becomes 1.
  - Required: req_out stays 0 until ack_s drops, then the handshake proceeds normally.
- With PULSE_HS_TX_TIMEOUT_EN and TIMEOUT_CYC=8: ack never returns.
  - Required: 8 cycles after req_out rises, req_out=0 and timeout_err=1 (sticky).
  - Required: no done_pulse; the next queued event still launches after GAP.
